// File: rtl/lock_pkg.sv
// Shared definitions for the keypad sequence-lock path: result codes,
// transmitter FSM states and the factory default access code.
package lock_pkg;

    // Outcome reported by the transmitter once a frame has been answered
    typedef logic [1:0] result_t;

    localparam result_t RES_NONE    = 2'b00;
    localparam result_t RES_UNLOCK  = 2'b01;
    localparam result_t RES_ALARM   = 2'b10;
    localparam result_t RES_TIMEOUT = 2'b11;

    // Transmitter control states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } tx_state_t;

    // Factory default code, also programmed into the sequence detector
    localparam logic [15:0] LOCK_DEFAULT_CODE = 16'h1732;

endpackage

// File: rtl/piso_shift.sv
// Parallel-load, MSB-first shift register with a down-counting bit index.
// 'last' is high while the LSB of the loaded word is on 'msb'.
module piso_shift #(
    parameter int          W    = 16,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] data_in,
    output logic         msb,
    output logic         last
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

    logic [W-1:0]  shift_reg;
    logic [W-1:0]  shift_next;
    logic [CW-1:0] cnt_reg;

    // Shifted-left image of the register, zero filled from the bottom
    assign shift_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < W; gi++) begin : g_shift
            assign shift_next[gi] = shift_reg[gi-1];
        end
    endgenerate

    // Load a new word or advance one bit toward the LSB
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= INIT;
            cnt_reg   <= '0;
        end else if (load) begin
            shift_reg <= data_in;
            cnt_reg   <= CNT_TOP;
        end else if (shift) begin
            shift_reg <= shift_next;
            if (cnt_reg != '0) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

    assign msb  = shift_reg[W-1];
    assign last = (cnt_reg == '0);

endmodule

// File: rtl/code_serial_tx.sv
// Serial access-code transmitter: accepts a parallel code, shifts it out
// MSB first one bit per clock, then waits a bounded window for the
// detector's unlock/alarm feedback and reports the outcome.
module code_serial_tx
    import lock_pkg::*;
#(
    parameter int               CODE_W       = 16,
    parameter logic             IDLE_LEVEL   = 1'b0,
    parameter int               RESP_TIMEOUT = 4,
    parameter logic [CODE_W-1:0] DEFAULT_CODE = CODE_W'(LOCK_DEFAULT_CODE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_valid,
    output logic              code_ready,
    output logic              ser_out,
    output logic              ser_valid,
    input  logic              unlock_in,
    input  logic              alarm_in,
    output logic              busy,
    output logic              done,
    output logic [1:0]        result
);

    localparam int TW = $clog2(RESP_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(RESP_TIMEOUT - 1);

    tx_state_t     state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    result_t       result_reg, result_next;
    logic          done_reg, done_next;
    logic          code_ready_reg;
    logic          load;
    logic          shift;
    logic          bit_msb;
    logic          bit_last;

    piso_shift #(
        .W    (CODE_W),
        .INIT (DEFAULT_CODE)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .shift   (shift),
        .data_in (code_in),
        .msb     (bit_msb),
        .last    (bit_last)
    );

    // Next-state, response timer and result decisions
    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        result_next = result_reg;
        done_next   = 1'b0;
        load        = 1'b0;
        shift       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (code_valid && code_ready_reg) begin
                    load       = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                shift = 1'b1;
                if (bit_last) begin
                    state_next = WAIT;
                    timer_next = '0;
                end
            end
            WAIT: begin
                timer_next = timer_reg + 1'b1;
                // unlock wins over alarm when both arrive together
                if (unlock_in) begin
                    result_next = RES_UNLOCK;
                    done_next   = 1'b1;
                    state_next  = DONE;
                end else if (alarm_in) begin
                    result_next = RES_ALARM;
                    done_next   = 1'b1;
                    state_next  = DONE;
                end else if (timer_reg == TIMER_LAST) begin
                    result_next = RES_TIMEOUT;
                    done_next   = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, timer, result and registered handshake ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            timer_reg      <= '0;
            result_reg     <= RES_NONE;
            done_reg       <= 1'b0;
            code_ready_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            result_reg     <= result_next;
            done_reg       <= done_next;
            code_ready_reg <= (state_next == IDLE);
        end
    end

    assign ser_valid  = (state_reg == SEND);
    assign ser_out    = ser_valid ? bit_msb : IDLE_LEVEL;
    assign busy       = (state_reg == SEND) || (state_reg == WAIT);
    assign done       = done_reg;
    assign result     = result_reg;
    assign code_ready = code_ready_reg;

endmodule

// File: tb/tb_code_serial_tx.sv
// Directed self-checking bench for code_serial_tx; the bench plays the
// role of the sequence detector by driving unlock_in/alarm_in.
module tb_code_serial_tx;
    import lock_pkg::*;

    localparam int CODE_W       = 16;
    localparam int RESP_TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CODE_W-1:0] code_in = '0;
    logic              code_valid = 1'b0;
    logic              code_ready;
    logic              ser_out;
    logic              ser_valid;
    logic              unlock_in = 1'b0;
    logic              alarm_in = 1'b0;
    logic              busy;
    logic              done;
    logic [1:0]        result;

    int n_cmp = 0;
    int n_bad = 0;

    code_serial_tx #(
        .CODE_W       (CODE_W),
        .IDLE_LEVEL   (1'b0),
        .RESP_TIMEOUT (RESP_TIMEOUT),
        .DEFAULT_CODE (16'h1732)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .unlock_in  (unlock_in),
        .alarm_in   (alarm_in),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!code_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_wait", code_ready, 1);
    endtask

    // One complete frame: handshake, 16 bit checks, response window, result
    task automatic run_frame(input logic [15:0] code, input logic unl, input logic alm,
                             input logic [1:0] exp_res, input int exp_wait);
        int n;
        wait_ready();
        code_in    = code;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        for (int i = 0; i < CODE_W; i++) begin
            chk("send_valid", ser_valid, 1);
            chk("send_bit", ser_out, code[CODE_W-1-i]);
            chk("send_ready", code_ready, 0);
            chk("send_busy", busy, 1);
            // a stray request mid-frame with a different code must be ignored
            if (i == 5) begin
                code_in    = ~code;
                code_valid = 1'b1;
            end else begin
                code_valid = 1'b0;
            end
            tick();
        end
        code_valid = 1'b0;
        unlock_in  = unl;
        alarm_in   = alm;
        n = 0;
        while (!done && n < 10) begin
            chk("wait_valid", ser_valid, 0);
            chk("wait_line", ser_out, 0);
            chk("wait_busy", busy, 1);
            tick();
            unlock_in = 1'b0;
            n++;
        end
        chk("wait_cycles", n, exp_wait);
        chk("done_pulse", done, 1);
        chk("result", result, exp_res);
        chk("done_busy", busy, 0);
        alarm_in = 1'b0;
        tick();
        chk("done_single", done, 0);
        chk("result_held", result, exp_res);
        $display("frame code=%04h unl=%0d alm=%0d -> result=%02b after %0d wait cycles",
                 code, unl, alm, result, n);
    endtask

    initial begin
        int hs[$];
        int vcount;
        int zeros;
        int overlap;
        int done_cnt;

        // Reset state
        tick();
        tick();
        chk("rst_ser_out", ser_out, 0);
        chk("rst_ser_valid", ser_valid, 0);
        chk("rst_ready", code_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, RES_NONE);
        rst = 1'b0;
        tick();
        chk("idle_ready", code_ready, 1);

        // Correct code: detector answers with unlock in first WAIT cycle
        run_frame(16'h1732, 1'b1, 1'b0, RES_UNLOCK, 1);
        // Wrong code three times: no feedback -> timeout after 4 WAIT cycles
        run_frame(16'hFFFF, 1'b0, 1'b0, RES_TIMEOUT, RESP_TIMEOUT);
        run_frame(16'hFFFF, 1'b0, 1'b0, RES_TIMEOUT, RESP_TIMEOUT);
        run_frame(16'hFFFF, 1'b0, 1'b0, RES_TIMEOUT, RESP_TIMEOUT);
        // Fourth wrong attempt: detector alarm level is up
        run_frame(16'hFFFF, 1'b0, 1'b1, RES_ALARM, 1);
        // Unlock and alarm together: unlock wins
        run_frame(16'h0F0F, 1'b1, 1'b1, RES_UNLOCK, 1);

        // code_valid held high: frames must be spaced CODE_W+RESP_TIMEOUT+2
        vcount  = 0;
        zeros   = 0;
        overlap = 0;
        code_valid = 1'b1;
        code_in    = 16'hFFFF;
        for (int c = 0; c < 66; c++) begin
            if (code_ready) begin
                hs.push_back(c);
                code_in = 16'hFFFF;
            end else begin
                code_in = 16'($urandom);
            end
            if (ser_valid) begin
                vcount++;
                if (!ser_out) zeros++;
            end
            if (code_ready && busy) overlap++;
            tick();
        end
        code_valid = 1'b0;
        chk("bb_handshakes", hs.size(), 3);
        chk("bb_gap1", (hs.size() > 1) ? hs[1] - hs[0] : -1, CODE_W + RESP_TIMEOUT + 2);
        chk("bb_gap2", (hs.size() > 2) ? hs[2] - hs[1] : -1, CODE_W + RESP_TIMEOUT + 2);
        chk("bb_valid_cycles", vcount, 3 * CODE_W);
        chk("bb_code_kept", zeros, 0);
        chk("bb_overlap", overlap, 0);
        chk("bb_result", result, RES_TIMEOUT);
        $display("back-to-back: %0d handshakes, %0d serial cycles", hs.size(), vcount);

        // Reset while bit 7 is on the line
        wait_ready();
        code_in    = 16'h1732;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        repeat (7) tick();
        chk("pre_rst_valid", ser_valid, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_ser_out", ser_out, 0);
        chk("mid_rst_valid", ser_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_result", result, RES_NONE);
        chk("mid_rst_ready", code_ready, 0);
        rst = 1'b0;
        done_cnt = 0;
        tick();
        chk("post_rst_ready", code_ready, 1);
        for (int c = 0; c < 25; c++) begin
            if (done) done_cnt++;
            tick();
        end
        chk("post_rst_no_done", done_cnt, 0);
        chk("post_rst_result", result, RES_NONE);
        $display("mid-frame reset: line=%0d valid=%0d result=%02b", ser_out, ser_valid, result);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
